// File: rtl/mem_io_pkg.sv
// Shared types for the SLC-3 memory / memory-mapped I/O controller.
package mem_io_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        DONE
    } state_e;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU request/ready bus and async SRAM pins of the memory controller.
// master = CPU side, slave = controller, mem = SRAM device.
interface mem_io_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_OE;
    logic              sram_WE;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_rdata,
        output cpu_rdata, cpu_ready, sram_addr, sram_wdata, sram_OE, sram_WE
    );

    modport mem (
        input  sram_addr, sram_wdata, sram_OE, sram_WE,
        output sram_rdata
    );
endinterface

// File: rtl/mem_io_sw_sync.sv
// Two-flop synchronizer for the asynchronous board switches.
module mem_io_sw_sync #(
    parameter int SW_W = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [SW_W-1:0] sw_in,
    output logic [SW_W-1:0] sw_out
);
    logic [SW_W-1:0] meta_q;
    logic [SW_W-1:0] sync_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= sw_in;
            sync_q <= meta_q;
        end
    end

    assign sw_out = sync_q;
endmodule

// File: rtl/mem_io_ctrl.sv
// SLC-3 memory / MMIO controller: request/ready handshake, SRAM wait states, hex register, switch port.
// Define MEM_IO_SW_SYNC_EN to route Switches through a 2-flop synchronizer.
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter int                NUM_HEX     = 4,
    parameter int                SW_W        = 10,
    parameter logic [ADDR_W-1:0] IO_ADDR     = {ADDR_W{1'b1}}
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_io_ctrl_if.slave         bus,
    input  logic [SW_W-1:0]      Switches,
    output logic [4*NUM_HEX-1:0] hex_out
);
    state_e                  state_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic                    we_q;
    logic                    oe_n_q;
    logic                    we_n_q;
    logic                    ready_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [4*NUM_HEX-1:0]    hex_q;
    logic [SW_W-1:0]         sw_s;
    logic [DATA_W-1:0]       sw_ext;

`ifdef MEM_IO_SW_SYNC_EN
    mem_io_sw_sync #(.SW_W(SW_W)) u_sw_sync (
        .Clk    (Clk),
        .Reset  (Reset),
        .sw_in  (Switches),
        .sw_out (sw_s)
    );
`else
    assign sw_s = Switches;
`endif

    assign sw_ext = DATA_W'(sw_s);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q <= bus.cpu_we;
                        if (bus.cpu_addr == IO_ADDR) begin
                            if (bus.cpu_we) hex_q   <= bus.cpu_wdata[4*NUM_HEX-1:0];
                            else            rdata_q <= sw_ext;
                            ready_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // SRAM address/data are valid from SETUP onward to give setup time
                            addr_q  <= bus.cpu_addr;
                            wdata_q <= bus.cpu_wdata;
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
                    oe_n_q  <= we_q;
                    we_n_q  <= !we_q;
                    state_q <= STROBE;
                end
                STROBE: begin
                    if (cnt_q == '0) begin
                        if (!we_q) rdata_q <= bus.sram_rdata;
                        oe_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata  = rdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_OE    = oe_n_q;
    assign bus.sram_WE    = we_n_q;
    assign hex_out        = hex_q;
endmodule
